// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and lane helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD} mem_size_t;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    function automatic logic [3:0] byte_en(mem_size_t sz, logic [1:0] a);
        return sz == SZ_BYTE ? 4'b0001 << a :
               sz == SZ_HALF ? (a[1] ? 4'b1100 : 4'b0011) :
               sz == SZ_WORD ? 4'b1111 : 4'b0000;
    endfunction

    function automatic logic [31:0] store_lanes(mem_size_t sz, logic [31:0] d);
        return sz == SZ_BYTE ? {4{d[7:0]}} : sz == SZ_HALF ? {2{d[15:0]}} : d;
    endfunction

    function automatic logic [31:0] load_ext(mem_size_t sz, logic uns, logic [1:0] a, logic [31:0] w);
        logic [31:0] s;
        s = w >> {a, 3'b000};
        return sz == SZ_BYTE ? {{24{~uns & s[7]}}, s[7:0]} :
               sz == SZ_HALF ? {{16{~uns & s[15]}}, s[15:0]} : w;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: DEPTH x 32 array, byte-lane synchronous write, combinational read.
module dmem_ram #(
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = "",
  localparam int   AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH] = '{default: '0};
  assign rdata = mem[addr];
  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked wait-state RAM slave for the core's data-memory port.
module dmem_responder import dmem_pkg::*; #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LATENCY   = 2,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ReqM,
    input  logic        MemWriteM,
    input  logic [1:0]  SizeM,
    input  logic        UnsignedM,
    input  logic [31:0] DataAdrM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        ReadyM,
    output logic        ErrM
);
    localparam int AW = $clog2(DEPTH);

    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be 0..15");
    end

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q;
    logic [31:0] adr_q, wd_q, adr, off, rdata;
    mem_size_t   size_q, size;
    logic        uns_q, we_q, uns, idle, err;

    // In IDLE the live inputs drive the lookup so LATENCY=0 can respond next cycle
    assign idle = state_q == IDLE;
    assign adr  = idle ? DataAdrM : adr_q;
    assign size = idle ? mem_size_t'(SizeM) : size_q;
    assign uns  = idle ? UnsignedM : uns_q;
    assign off  = adr - BASE_ADDR;
    assign err  = size == SZ_RSVD || (size == SZ_HALF && adr[0]) || (size == SZ_WORD && |adr[1:0]) ||
                  adr < BASE_ADDR || (off >> 2) >= 32'(DEPTH);

    assign state_d = idle ? (ReqM ? (LATENCY == 0 ? RESP : WAIT) : IDLE) :
                     state_q == WAIT ? (cnt_q == 4'd1 ? RESP : WAIT) : IDLE;

    assign ReadyM = state_q == RESP;
    assign ErrM   = ReadyM & err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            adr_q     <= '0;
            wd_q      <= '0;
            size_q    <= SZ_BYTE;
            uns_q     <= 1'b0;
            we_q      <= 1'b0;
            ReadDataM <= '0;
        end else begin
            state_q <= state_d;
            if (idle && ReqM) begin
                cnt_q  <= 4'(LATENCY);
                adr_q  <= DataAdrM;
                wd_q   <= WriteDataM;
                size_q <= mem_size_t'(SizeM);
                uns_q  <= UnsignedM;
                we_q   <= MemWriteM;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (state_d == RESP && !ReadyM)
                ReadDataM <= err ? '0 : load_ext(size, uns, adr[1:0], rdata);
        end
    end

    dmem_ram #(.DEPTH(DEPTH), .INIT_FILE(INIT_FILE)) u_ram (
        .clk   (clk),
        .we    (ReadyM & we_q & ~err),
        .be    (byte_en(size_q, adr_q[1:0])),
        .addr  (off[AW+1:2]),
        .wdata (store_lanes(size_q, wd_q)),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vectors against LATENCY=2 and LATENCY=0 responders.
module tb_dmem_responder;
    logic        clk = 0, reset_n = 0;
    logic        req2 = 0, we2 = 0, uns2 = 0, rdy2, err2;
    logic [1:0]  sz2 = 0;
    logic [31:0] adr2 = 0, wd2 = 0, rd2;
    logic        req0 = 0, we0 = 0, uns0 = 0, rdy0, err0;
    logic [1:0]  sz0 = 0;
    logic [31:0] adr0 = 0, wd0 = 0, rd0;
    int n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(2)) u2 (
        .clk(clk), .reset_n(reset_n), .ReqM(req2), .MemWriteM(we2), .SizeM(sz2), .UnsignedM(uns2),
        .DataAdrM(adr2), .WriteDataM(wd2), .ReadDataM(rd2), .ReadyM(rdy2), .ErrM(err2)
    );

    dmem_responder #(.LATENCY(0)) u0 (
        .clk(clk), .reset_n(reset_n), .ReqM(req0), .MemWriteM(we0), .SizeM(sz0), .UnsignedM(uns0),
        .DataAdrM(adr0), .WriteDataM(wd0), .ReadDataM(rd0), .ReadyM(rdy0), .ErrM(err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic access(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk);
        req2 = 1; we2 = w; sz2 = sz; uns2 = u; adr2 = a; wd2 = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rdy2 && lat < 20);
        rd = rd2; e = err2;
        req2 = 0;
    endtask

    task automatic st(input string tag, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                      input logic exp_err);
        logic [31:0] rd; logic e; int lat;
        access(1'b1, sz, 1'b0, a, d, rd, e, lat);
        check({tag, " lat"}, 32'(lat), 32'd3);
        check({tag, " err"}, {31'd0, e}, {31'd0, exp_err});
    endtask

    task automatic ld(input string tag, input logic [1:0] sz, input logic u, input logic [31:0] a,
                      input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd; logic e; int lat;
        access(1'b0, sz, u, a, 32'h0, rd, e, lat);
        check({tag, " lat"}, 32'(lat), 32'd3);
        check({tag, " err"}, {31'd0, e}, {31'd0, exp_err});
        check({tag, " data"}, rd, exp_rd);
    endtask

    initial begin
        #12;
        check("rst rdy", {31'd0, rdy2}, 32'd0);
        check("rst err", {31'd0, err2}, 32'd0);
        check("rst data", rd2, 32'd0);
        check("rst rdy0", {31'd0, rdy0}, 32'd0);
        @(negedge clk) reset_n = 1;

        st("sw 100", 2'b10, 32'h100, 32'hDEADBEEF, 1'b0);
        ld("lw 100", 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0);

        st("sw 104", 2'b10, 32'h104, 32'h0, 1'b0);
        st("sb 105", 2'b00, 32'h105, 32'h000000AB, 1'b0);
        ld("lw 104 a", 2'b10, 1'b0, 32'h104, 32'h0000AB00, 1'b0);
        st("sh 106", 2'b01, 32'h106, 32'h00001234, 1'b0);
        ld("lw 104 b", 2'b10, 1'b0, 32'h104, 32'h1234AB00, 1'b0);

        st("sw 108", 2'b10, 32'h108, 32'h00008080, 1'b0);
        ld("lb 108", 2'b00, 1'b0, 32'h108, 32'hFFFFFF80, 1'b0);
        ld("lbu 108", 2'b00, 1'b1, 32'h108, 32'h00000080, 1'b0);
        ld("lh 108", 2'b01, 1'b0, 32'h108, 32'hFFFF8080, 1'b0);
        ld("lhu 108", 2'b01, 1'b1, 32'h108, 32'h00008080, 1'b0);
        ld("lbu 109", 2'b00, 1'b1, 32'h109, 32'h00000080, 1'b0);

        ld("lw 102", 2'b10, 1'b0, 32'h102, 32'h0, 1'b1);
        st("sh 101", 2'b01, 32'h101, 32'h00005555, 1'b1);
        ld("lw 100 kept", 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0);
        ld("lw oob", 2'b10, 1'b0, 32'h1000, 32'h0, 1'b1);
        ld("lw last", 2'b10, 1'b0, 32'hFFC, 32'h0, 1'b0);
        ld("rsvd size", 2'b11, 1'b0, 32'h100, 32'h0, 1'b1);

        st("sw 10C", 2'b10, 32'h10C, 32'h11111111, 1'b0);
        ld("lw 10C", 2'b10, 1'b0, 32'h10C, 32'h11111111, 1'b0);
        @(negedge clk);
        req2 = 1; we2 = 1; sz2 = 2'b10; adr2 = 32'h10C; wd2 = 32'h22222222;
        @(negedge clk);
        reset_n = 0; req2 = 0;
        #1;
        check("mid rst rdy", {31'd0, rdy2}, 32'd0);
        check("mid rst err", {31'd0, err2}, 32'd0);
        check("mid rst data", rd2, 32'd0);
        @(negedge clk) reset_n = 1;
        ld("lw 10C kept", 2'b10, 1'b0, 32'h10C, 32'h11111111, 1'b0);

        @(negedge clk);
        req0 = 1; we0 = 1; sz0 = 2'b10; uns0 = 0; adr0 = 32'h100; wd0 = 32'hCAFEF00D;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("lat0 rdy c%0d", c), {31'd0, rdy0}, {31'd0, c[0]});
            if (c == 1) we0 = 0;
            if (c == 3) begin
                check("lat0 lw", rd0, 32'hCAFEF00D);
                adr0 = 32'h102; sz0 = 2'b01; uns0 = 1;
            end
            if (c == 5) begin
                check("lat0 lhu", rd0, 32'h0000CAFE);
                check("lat0 err", {31'd0, err0}, 32'd0);
                req0 = 0;
            end
        end
        @(negedge clk);
        check("lat0 idle", {31'd0, rdy0}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
